otter_fetch: RTL and testbench

OTTER_FETCH -- requirements
Module: otter_fetch

---
 rtl/otter_fetch_pkg.sv | 25 ++
 rtl/otter_pc_reg.sv | 45 ++++
 rtl/otter_fetch.sv | 221 ++++++++++++++++++++++
 tb/tb_otter_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/otter_fetch_pkg.sv
// -----------------------------------------------------------------------------
// otter_fetch_pkg
// Shared types and constants for the OTTER instruction-fetch stage:
//   - fetch_state_t : fetch FSM states (REQ waits on memory, HOLD waits on decode)
//   - NOP_INSN      : instruction presented when no real word is available
//   - DEFAULT_*     : default parameter values for otter_fetch
//   - pc_add4       : 32-bit modulo PC increment shared by PC and PC_PLUS4 paths
// -----------------------------------------------------------------------------
package otter_fetch_pkg;

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSN               = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VEC      = 32'h0000_0000;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 16;

    // Wraps naturally: 32'hFFFF_FFFC + 4 gives 32'h0000_0000.
    function automatic logic [31:0] pc_add4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/otter_pc_reg.sv
// -----------------------------------------------------------------------------
// otter_pc_reg
// Program-counter register with load and +4 increment. Load wins over
// increment. Any alignment policy is applied by the caller on i_load_val.
// Ports:
//   i_clk, i_rst_n   clock / asynchronous active-low reset (PC <- RESET_VEC)
//   i_load           load i_load_val into PC
//   i_load_val       value to load
//   i_inc            advance PC by 4 (ignored when i_load is set)
//   o_pc             current PC
//   o_pc_plus4       current PC + 4 (modulo 2^32)
// -----------------------------------------------------------------------------
module otter_pc_reg
    import otter_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_inc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic [31:0] r_pc;

    // PC register: load has priority over the sequential advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_VEC;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= pc_add4(r_pc);
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = pc_add4(r_pc);

endmodule

// File: rtl/otter_fetch.sv
// -----------------------------------------------------------------------------
// otter_fetch
// Instruction-fetch stage for the OTTER core. Issues one instruction-memory
// read at a time at PC, captures the returned word into IR, and holds it until
// decode accepts it. Redirects (i_pc_write) can arrive in any state; a
// response belonging to a request issued before the redirect is squashed.
// A wait counter abandons a request that gets no response and retries it.
//
// Optional feature macro: FETCH_MISALIGN_EN
//   defined   : a redirect to a non word-aligned address presents a NOP with
//               o_fetch_fault=1 instead of fetching.
//   undefined : redirect targets are forced word-aligned, o_fetch_fault is 0.
//
// Ports:
//   i_clk, i_rst_n  clock / asynchronous active-low reset
//   i_next_pc       redirect target from the PC-source mux
//   i_pc_write      redirect strobe
//   o_imem_req      instruction-memory read request
//   o_imem_addr     read address (= PC)
//   i_imem_valid    read-data-valid strobe
//   i_imem_rdata    read data
//   o_ir_valid      IR / PC_OUT hold a fetched instruction
//   i_ir_ready      decode accepts IR this cycle
//   o_ir            fetched instruction
//   o_pc_out        address of o_ir
//   o_pc_plus4      o_pc_out + 4
//   o_fetch_err     one-cycle pulse when a request times out
//   o_fetch_fault   misaligned redirect presented with o_ir_valid
// -----------------------------------------------------------------------------
module otter_fetch
    import otter_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC      = DEFAULT_RESET_VEC,
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_next_pc,
    input  logic        i_pc_write,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_ir_valid,
    input  logic        i_ir_ready,
    output logic [31:0] o_ir,
    output logic [31:0] o_pc_out,
    output logic [31:0] o_pc_plus4,
    output logic        o_fetch_err,
    output logic        o_fetch_fault
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t     r_state,      w_state_nxt;
    logic             r_imem_req,   w_imem_req_nxt;
    logic             r_squash,     w_squash_nxt;
    logic [CNT_W-1:0] r_wait_cnt,   w_wait_cnt_nxt;
    logic [31:0]      r_ir,         w_ir_nxt;
    logic [31:0]      r_pc_out,     w_pc_out_nxt;
    logic [31:0]      r_pc_plus4,   w_pc_plus4_nxt;
    logic             r_ir_valid;
    logic             r_fetch_err;
    logic             r_fetch_fault, w_fetch_fault_nxt;

    logic [31:0]      w_pc;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_pc_load_val;
    logic             w_pc_load;
    logic             w_pc_inc;
    logic             w_misalign;
    logic             w_resp;
    logic             w_accept;
    logic             w_waiting;
    logic             w_timeout;

`ifdef FETCH_MISALIGN_EN
    assign w_misalign    = (i_next_pc[1:0] != 2'b00);
    assign w_pc_load_val = i_next_pc;
`else
    assign w_misalign    = 1'b0;
    assign w_pc_load_val = {i_next_pc[31:2], 2'b00};
`endif

    otter_pc_reg #(
        .RESET_VEC (RESET_VEC)
    ) u_pc_reg (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_pc_load),
        .i_load_val (w_pc_load_val),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc),
        .o_pc_plus4 (w_pc_plus4)
    );

    // A response ends the single outstanding request, whether live or squashed.
    // Only a live request's response, with no redirect this cycle, is kept.
    assign w_resp    = i_imem_valid && (r_imem_req || r_squash);
    assign w_accept  = w_resp && r_imem_req && !i_pc_write;
    assign w_waiting = (r_state == ST_REQ) && (r_imem_req || r_squash) &&
                       !i_imem_valid && !i_pc_write;
    assign w_timeout = w_waiting && (r_wait_cnt == CNT_LAST);

    // FSM next state, PC control and IR/PC_OUT capture; redirect wins in any state.
    always_comb begin
        w_state_nxt       = r_state;
        w_ir_nxt          = r_ir;
        w_pc_out_nxt      = r_pc_out;
        w_pc_plus4_nxt    = r_pc_plus4;
        w_fetch_fault_nxt = r_fetch_fault;
        w_pc_load         = 1'b0;
        w_pc_inc          = 1'b0;
        if (i_pc_write) begin
            w_pc_load = 1'b1;
            if (w_misalign) begin
                // Present the bad target as a faulting NOP without touching memory.
                w_state_nxt       = ST_HOLD;
                w_ir_nxt          = NOP_INSN;
                w_pc_out_nxt      = i_next_pc;
                w_pc_plus4_nxt    = pc_add4(i_next_pc);
                w_fetch_fault_nxt = 1'b1;
            end else begin
                w_state_nxt       = ST_REQ;
                w_fetch_fault_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_accept) begin
                        w_state_nxt       = ST_HOLD;
                        w_ir_nxt          = i_imem_rdata;
                        w_pc_out_nxt      = w_pc;
                        w_pc_plus4_nxt    = w_pc_plus4;
                        w_fetch_fault_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (i_ir_ready) begin
                        w_state_nxt       = ST_REQ;
                        w_pc_inc          = 1'b1;
                        w_fetch_fault_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                default: begin
                    w_state_nxt = ST_REQ;
                end
            endcase
        end
    end

    // Squash tracking: a redirect while a request is live marks its response stale.
    always_comb begin
        w_squash_nxt = r_squash;
        if (w_timeout) begin
            w_squash_nxt = 1'b0;
        end else if (w_resp) begin
            w_squash_nxt = 1'b0;
        end else if (i_pc_write && r_imem_req) begin
            w_squash_nxt = 1'b1;
        end else begin
            w_squash_nxt = r_squash;
        end
    end

    // Wait counter and request enable; a timeout drops the request for one cycle.
    always_comb begin
        w_wait_cnt_nxt = '0;
        if (w_timeout) begin
            w_wait_cnt_nxt = '0;
        end else if (w_waiting) begin
            w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end else begin
            w_wait_cnt_nxt = '0;
        end
        // No new request while a squashed response is still owed.
        w_imem_req_nxt = (w_state_nxt == ST_REQ) && !w_squash_nxt && !w_timeout;
    end

    // All fetch-stage state and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_REQ;
            r_imem_req    <= 1'b0;
            r_squash      <= 1'b0;
            r_wait_cnt    <= '0;
            r_ir          <= NOP_INSN;
            r_pc_out      <= 32'h0000_0000;
            r_pc_plus4    <= 32'h0000_0004;
            r_ir_valid    <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_fetch_fault <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_imem_req    <= w_imem_req_nxt;
            r_squash      <= w_squash_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_ir          <= w_ir_nxt;
            r_pc_out      <= w_pc_out_nxt;
            r_pc_plus4    <= w_pc_plus4_nxt;
            r_ir_valid    <= (w_state_nxt == ST_HOLD);
            r_fetch_err   <= w_timeout;
            r_fetch_fault <= w_fetch_fault_nxt;
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = w_pc;
    assign o_ir_valid    = r_ir_valid;
    assign o_ir          = r_ir;
    assign o_pc_out      = r_pc_out;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_fetch_err   = r_fetch_err;
    assign o_fetch_fault = r_fetch_fault;

endmodule

// File: tb/tb_otter_fetch.sv
// -----------------------------------------------------------------------------
// tb_otter_fetch
// Directed, table-driven bench for otter_fetch (default parameters). The main
// table walks fetch, hold, handshake, redirect, squash and PC wrap; hand-written
// sequences cover reset mid-request, the timeout/retry and misaligned redirects.
// -----------------------------------------------------------------------------
module tb_otter_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        pc_write;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_err;
    logic        fetch_fault;

    int n_cmp  = 0;
    int n_fail = 0;

    otter_fetch dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_next_pc     (next_pc),
        .i_pc_write    (pc_write),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_valid  (imem_valid),
        .i_imem_rdata  (imem_rdata),
        .o_ir_valid    (ir_valid),
        .i_ir_ready    (ir_ready),
        .o_ir          (ir),
        .o_pc_out      (pc_out),
        .o_pc_plus4    (pc_plus4),
        .o_fetch_err   (fetch_err),
        .o_fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pw;
        logic [31:0] npc;
        logic        vld;
        logic [31:0] rd;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_irv;
        logic [31:0] e_ir;
        logic [31:0] e_pco;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t tbl [0:22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        pc_write   = 1'b0;
        next_pc    = 32'h0000_0000;
        imem_valid = 1'b0;
        imem_rdata = 32'h0000_0000;
        ir_ready   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over two edges, check reset outputs, release between edges.
    task automatic apply_reset(input logic hold_valid);
        idle_inputs();
        imem_valid = hold_valid;
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req",   32'(imem_req),    32'h0);
        chk("rst.addr",  imem_addr,        32'h0);
        chk("rst.ir",    ir,               NOP);
        chk("rst.pcout", pc_out,           32'h0);
        chk("rst.irv",   32'(ir_valid),    32'h0);
        chk("rst.err",   32'(fetch_err),   32'h0);
        chk("rst.fault", 32'(fetch_fault), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_cyc;
        int req_hi;
        rst_n = 1'b0;
        idle_inputs();

        //          pw    npc           vld   rd            rdy   req   addr          irv   ir            pc_out        pc+4
        tbl[0]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0,        32'h0};
        tbl[1]  = '{1'b0, 32'h0,        1'b1, 32'h00500093, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00500093, 32'h0,        32'h4};
        tbl[2]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h00500093, 32'h0,        32'h4};
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = tbl[2];
        tbl[6]  = tbl[2];
        tbl[7]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b0, 32'h0,        32'h0,        32'h0};
        tbl[8]  = '{1'b0, 32'h0,        1'b1, 32'h00208133, 1'b0, 1'b0, 32'h4,        1'b1, 32'h00208133, 32'h4,        32'h8};
        tbl[9]  = '{1'b1, 32'h40,       1'b0, 32'h0,        1'b1, 1'b1, 32'h40,       1'b0, 32'h0,        32'h0,        32'h0};
        tbl[10] = '{1'b0, 32'h0,        1'b1, 32'h00000073, 1'b0, 1'b0, 32'h40,       1'b1, 32'h00000073, 32'h40,       32'h44};
        tbl[11] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h44,       1'b0, 32'h0,        32'h0,        32'h0};
        tbl[12] = '{1'b1, 32'h100,      1'b0, 32'h0,        1'b0, 1'b0, 32'h100,      1'b0, 32'h0,        32'h0,        32'h0};
        tbl[13] = '{1'b0, 32'h0,        1'b1, 32'hBAD0BAD0, 1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        32'h0,        32'h0};
        tbl[14] = '{1'b0, 32'h0,        1'b1, 32'h00000513, 1'b0, 1'b0, 32'h100,      1'b1, 32'h00000513, 32'h100,      32'h104};
        tbl[15] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      1'b0, 32'h0,        32'h0,        32'h0};
        tbl[16] = '{1'b1, 32'h200,      1'b1, 32'hBAD0BAD1, 1'b0, 1'b1, 32'h200,      1'b0, 32'h0,        32'h0,        32'h0};
        tbl[17] = '{1'b0, 32'h0,        1'b1, 32'h00100093, 1'b0, 1'b0, 32'h200,      1'b1, 32'h00100093, 32'h200,      32'h204};
        tbl[18] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h204,      1'b0, 32'h0,        32'h0,        32'h0};
        tbl[19] = '{1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        1'b0, 1'b0, 32'hFFFFFFFC, 1'b0, 32'h0,        32'h0,        32'h0};
        tbl[20] = '{1'b0, 32'h0,        1'b1, 32'hBAD0BAD2, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        32'h0,        32'h0};
        tbl[21] = '{1'b0, 32'h0,        1'b1, 32'h00000013, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b1, 32'h00000013, 32'hFFFFFFFC, 32'h0};
        tbl[22] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0,        32'h0};

        // Main table: starts in the first cycle after reset release.
        apply_reset(1'b0);
        for (int i = 0; i <= 22; i++) begin
            pc_write   = tbl[i].pw;
            next_pc    = tbl[i].npc;
            imem_valid = tbl[i].vld;
            imem_rdata = tbl[i].rd;
            ir_ready   = tbl[i].rdy;
            step();
            chk($sformatf("v%0d.req", i),   32'(imem_req),    32'(tbl[i].e_req));
            chk($sformatf("v%0d.addr", i),  imem_addr,        tbl[i].e_addr);
            chk($sformatf("v%0d.irv", i),   32'(ir_valid),    32'(tbl[i].e_irv));
            chk($sformatf("v%0d.err", i),   32'(fetch_err),   32'h0);
            chk($sformatf("v%0d.fault", i), 32'(fetch_fault), 32'h0);
            if (tbl[i].e_irv) begin
                chk($sformatf("v%0d.ir", i),   ir,       tbl[i].e_ir);
                chk($sformatf("v%0d.pco", i),  pc_out,   tbl[i].e_pco);
                chk($sformatf("v%0d.pc4", i),  pc_plus4, tbl[i].e_pc4);
            end
        end

        // Reset mid-request with a late IMEM_VALID still high across release.
        idle_inputs();
        apply_reset(1'b1);
        step();
        chk("late.irv",  32'(ir_valid), 32'h0);
        chk("late.req",  32'(imem_req), 32'h1);
        chk("late.addr", imem_addr,     32'h0);
        imem_valid = 1'b0;
        step();
        chk("late.irv2", 32'(ir_valid), 32'h0);
        chk("late.req2", 32'(imem_req), 32'h1);

        // Timeout: memory never answers.
        apply_reset(1'b0);
        err_cyc = 0;
        req_hi  = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (fetch_err) begin
                err_cyc = c;
                break;
            end
            if (imem_req) req_hi++;
        end
        chk("tmo.err_cycle", 32'(err_cyc),  32'd17);
        chk("tmo.req_hi",    32'(req_hi),   32'd16);
        chk("tmo.req_drop",  32'(imem_req), 32'h0);
        step();
        chk("tmo.err_pulse", 32'(fetch_err), 32'h0);
        chk("tmo.retry_req", 32'(imem_req),  32'h1);
        chk("tmo.retry_adr", imem_addr,      32'h0);

        // Misaligned redirect issued before any request is outstanding.
        apply_reset(1'b0);
        pc_write = 1'b1;
        next_pc  = 32'h0000_0102;
        step();
        idle_inputs();
`ifdef FETCH_MISALIGN_EN
        chk("mis.irv",   32'(ir_valid),    32'h1);
        chk("mis.fault", 32'(fetch_fault), 32'h1);
        chk("mis.ir",    ir,               NOP);
        chk("mis.pco",   pc_out,           32'h0000_0102);
        chk("mis.req",   32'(imem_req),    32'h0);
        step();
        chk("mis.req2",  32'(imem_req),    32'h0);
        chk("mis.irv2",  32'(ir_valid),    32'h1);
`else
        chk("mis.irv",   32'(ir_valid),    32'h0);
        chk("mis.fault", 32'(fetch_fault), 32'h0);
        chk("mis.req",   32'(imem_req),    32'h1);
        chk("mis.addr",  imem_addr,        32'h0000_0100);
        step();
        chk("mis.req2",  32'(imem_req),    32'h1);
        chk("mis.addr2", imem_addr,        32'h0000_0100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
